// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 16-channel mux scan sequencer: sizes and FSM state encoding.
package mux_scan_pkg;

   localparam int unsigned NUM_CH = 16;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StFinish
   } scan_state_e;

endpackage

// File: rtl/next_ch_find.sv
// Combinational search for the next enabled channel, either the lowest overall or the lowest
// strictly above the current select.
module next_ch_find
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              first,
   output logic [SEL_W-1:0]  nxt,
   output logic              found
);

   // Walk downwards so the last hit written is the lowest qualifying index.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i] && (first || (i > int'(cur)))) begin
            nxt   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux16_scan_sequencer.sv
// Scans the enabled channels of a 16:1 bit mux in ascending order, waits a settle time on each,
// samples the mux output and publishes the assembled word with a done pulse.
module mux16_scan_sequencer #(
   parameter int unsigned NUM_CH        = 16,
   parameter int unsigned SEL_W         = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              mux_out,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] snapshot
);
   import mux_scan_pkg::*;

   if (NUM_CH != mux_scan_pkg::NUM_CH || SEL_W != mux_scan_pkg::SEL_W ||
       SETTLE_CYCLES > 15) begin : g_bad_cfg
      $error("mux16_scan_sequencer: unsupported NUM_CH/SEL_W/SETTLE_CYCLES");
   end

   localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES);
   localparam bit               NoSettle   = (SETTLE_CYCLES == 0);

   scan_state_e       state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d;
   logic [NUM_CH-1:0] snap_q, snap_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              find_first;
   logic [NUM_CH-1:0] find_mask;
   logic [SEL_W-1:0]  find_nxt;
   logic              find_found;

   // In idle the mask is not latched yet, so search the live input.
   assign find_first = (state_q == StIdle);
   assign find_mask  = find_first ? ch_mask : mask_q;

   next_ch_find u_find (
      .mask  (find_mask),
      .cur   (sel_q),
      .first (find_first),
      .nxt   (find_nxt),
      .found (find_found)
   );

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      snap_d   = snap_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mask_d   = ch_mask;
               shadow_d = '0;
               if (!find_found) begin
                  state_d = StFinish;
               end else begin
                  sel_d   = find_nxt;
                  cnt_d   = SettleLoad;
                  busy_d  = 1'b1;
                  state_d = NoSettle ? StSample : StSettle;
               end
            end
         end
         StSettle: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StSample;
            end
         end
         StSample: begin
            shadow_d[sel_q] = mux_out;
            if (find_found) begin
               sel_d   = find_nxt;
               cnt_d   = SettleLoad;
               state_d = NoSettle ? StSample : StSettle;
            end else begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            snap_d  = shadow_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mask_q   <= '0;
         shadow_q <= '0;
         snap_q   <= '0;
         sel_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sel      = sel_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign snapshot = snap_q;

endmodule
